// File: rtl/stf_sync_detect.sv
// ---------------------------------------------------------------------------
// stf_sync_detect
// Legacy short-training-field detector for the RX path. Computes a lag-16
// delayed autocorrelation and a signal power over a 16-sample moving window.
// It declares detection once the normalised correlation has cleared the
// threshold for MIN_PLATEAU consecutive samples.
//
// Pipeline (one sample per clock sustained):
//   S1  delay line push, s[n]*conj(s[n-16]) and |s[n]|^2, both >>> 4
//   S2  16-deep moving sums of the three products
//   S3  |re|+|im| against a power-scaled threshold, gated by warm-up/min power
//
// Optional build macro: STF_SYNC_CORR_LATCH_EN
//   defined     -> correlation sums are captured at detection (coarse CFO use)
//   not defined -> corr_*_latched tie to 0 and no capture registers exist
// ---------------------------------------------------------------------------
module stf_sync_detect #(
    parameter int MIN_PLATEAU  = 100,
    parameter int THRESH_SCALE = 6,
    parameter int MIN_POWER    = 64
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        enable,
    input  logic        clear,
    input  logic [31:0] sample_in,
    input  logic        sample_in_strobe,
    output logic        metric_valid,
    output logic [7:0]  plateau_cnt,
    output logic        short_preamble_detected,
    output logic [39:0] corr_re_latched,
    output logic [39:0] corr_im_latched
);

    localparam int          LAG          = 16;
    localparam int          WIN          = 16;
    localparam logic [5:0]  WARM_STROBES = 6'd32;
    localparam logic [7:0]  PLATEAU_TGT  = 8'(MIN_PLATEAU);
    localparam logic [47:0] THRESH_K     = 48'(THRESH_SCALE);
    localparam logic [39:0] POWER_MIN    = 40'(MIN_POWER);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SEARCH   = 2'd1,
        ST_DETECTED = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic restart;   // entering SEARCH this cycle (from IDLE or via clear)
    logic flush;     // wipe the datapath: leaving for IDLE or restarting
    logic take;      // accept the incoming sample into S1
    logic hit;       // this metric completes the plateau

    // ---------------- S1 state ----------------
    logic [31:0]        dl_q [LAG];
    logic [31:0]        dl_d [LAG];
    logic [5:0]         warm_cnt_q, warm_cnt_d;
    logic signed [33:0] prod_re_q, prod_re_d;
    logic signed [33:0] prod_im_q, prod_im_d;
    logic [32:0]        pwr_q, pwr_d;
    logic               v1_q, v1_d;
    logic               warm1_q, warm1_d;

    // ---------------- S2 state ----------------
    logic signed [33:0] hre_q [WIN];
    logic signed [33:0] hre_d [WIN];
    logic signed [33:0] him_q [WIN];
    logic signed [33:0] him_d [WIN];
    logic [32:0]        hpw_q [WIN];
    logic [32:0]        hpw_d [WIN];
    logic signed [39:0] sum_re_q, sum_re_d;
    logic signed [39:0] sum_im_q, sum_im_d;
    logic [39:0]        sum_pwr_q, sum_pwr_d;
    logic               v2_q, v2_d;
    logic               warm2_q, warm2_d;

    // ---------------- S3 / control state ----------------
    logic               qual_q, qual_d;
    logic               metric_valid_q, metric_valid_d;
    logic [7:0]         plateau_q, plateau_d;
    logic [7:0]         plateau_inc;

    // ---------------- S1 combinational helpers ----------------
    logic signed [15:0] i_cur, q_cur, i_dly, q_dly;
    logic signed [31:0] p_ii, p_qq, p_qi, p_iq, p_pi, p_pq;
    logic signed [33:0] re_full, im_full;
    logic [32:0]        pwr_full;

    // ---------------- S3 combinational helpers ----------------
    logic [39:0]        abs_re, abs_im;
    logic [40:0]        corr_abs;
    logic [47:0]        thr_lhs, thr_rhs;

    // Control qualifiers shared by every stage
    assign plateau_inc = (plateau_q == 8'hFF) ? 8'hFF : plateau_q + 8'd1;
    assign hit   = metric_valid_q && qual_q && (state_q == ST_SEARCH)
                   && (plateau_inc == PLATEAU_TGT);
    assign flush = !enable || restart;
    assign take  = sample_in_strobe && enable && !restart && (state_q != ST_IDLE);

    // Next-state logic; disabling wins over everything, including clear
    always_comb begin
        state_d = state_q;
        restart = 1'b0;
        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_SEARCH;
                    restart = 1'b1;
                end
                ST_SEARCH: begin
                    if (hit) state_d = ST_DETECTED;
                end
                ST_DETECTED: begin
                    if (clear) begin
                        state_d = ST_SEARCH;
                        restart = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // S1: delay line, warm-up counter and the three per-sample products
    always_comb begin
        i_cur    = sample_in[31:16];
        q_cur    = sample_in[15:0];
        i_dly    = dl_q[LAG-1][31:16];
        q_dly    = dl_q[LAG-1][15:0];
        p_ii     = i_cur * i_dly;
        p_qq     = q_cur * q_dly;
        p_qi     = q_cur * i_dly;
        p_iq     = i_cur * q_dly;
        p_pi     = i_cur * i_cur;
        p_pq     = q_cur * q_cur;
        re_full  = 34'(p_ii) + 34'(p_qq);
        im_full  = 34'(p_qi) - 34'(p_iq);
        pwr_full = {1'b0, p_pi} + {1'b0, p_pq};

        dl_d       = dl_q;
        warm_cnt_d = warm_cnt_q;
        prod_re_d  = prod_re_q;
        prod_im_d  = prod_im_q;
        pwr_d      = pwr_q;
        warm1_d    = warm1_q;
        v1_d       = 1'b0;
        if (flush) begin
            for (int k = 0; k < LAG; k++) dl_d[k] = '0;
            warm_cnt_d = '0;
            prod_re_d  = '0;
            prod_im_d  = '0;
            pwr_d      = '0;
            warm1_d    = 1'b0;
        end else if (take) begin
            dl_d[0] = sample_in;
            for (int k = 1; k < LAG; k++) dl_d[k] = dl_q[k-1];
            // warm once 32 samples already sit ahead of this one
            warm1_d    = (warm_cnt_q == WARM_STROBES);
            if (warm_cnt_q != WARM_STROBES) warm_cnt_d = warm_cnt_q + 6'd1;
            prod_re_d  = re_full >>> 4;
            prod_im_d  = im_full >>> 4;
            pwr_d      = pwr_full >> 4;
            v1_d       = 1'b1;
        end
    end

    // S2: moving sums; the entry falling off the 16-deep history is subtracted
    always_comb begin
        hre_d     = hre_q;
        him_d     = him_q;
        hpw_d     = hpw_q;
        sum_re_d  = sum_re_q;
        sum_im_d  = sum_im_q;
        sum_pwr_d = sum_pwr_q;
        warm2_d   = warm2_q;
        v2_d      = 1'b0;
        if (flush) begin
            for (int k = 0; k < WIN; k++) begin
                hre_d[k] = '0;
                him_d[k] = '0;
                hpw_d[k] = '0;
            end
            sum_re_d  = '0;
            sum_im_d  = '0;
            sum_pwr_d = '0;
            warm2_d   = 1'b0;
        end else if (v1_q) begin
            hre_d[0] = prod_re_q;
            him_d[0] = prod_im_q;
            hpw_d[0] = pwr_q;
            for (int k = 1; k < WIN; k++) begin
                hre_d[k] = hre_q[k-1];
                him_d[k] = him_q[k-1];
                hpw_d[k] = hpw_q[k-1];
            end
            sum_re_d  = sum_re_q + 40'(prod_re_q) - 40'(hre_q[WIN-1]);
            sum_im_d  = sum_im_q + 40'(prod_im_q) - 40'(him_q[WIN-1]);
            sum_pwr_d = sum_pwr_q + 40'(pwr_q) - 40'(hpw_q[WIN-1]);
            warm2_d   = warm1_q;
            v2_d      = 1'b1;
        end
    end

    // S3: L1 magnitude against THRESH_SCALE/8 of the window power
    always_comb begin
        abs_re   = sum_re_q[39] ? 40'(-sum_re_q) : 40'(sum_re_q);
        abs_im   = sum_im_q[39] ? 40'(-sum_im_q) : 40'(sum_im_q);
        corr_abs = {1'b0, abs_re} + {1'b0, abs_im};
        thr_lhs  = {4'd0, corr_abs, 3'd0};
        thr_rhs  = THRESH_K * {8'd0, sum_pwr_q};

        qual_d         = qual_q;
        metric_valid_d = 1'b0;
        if (flush) begin
            qual_d = 1'b0;
        end else if (v2_q) begin
            qual_d         = warm2_q && (sum_pwr_q >= POWER_MIN) && (thr_lhs > thr_rhs);
            metric_valid_d = 1'b1;
        end
    end

    // Plateau counter: counts only while searching, frozen once detected
    always_comb begin
        plateau_d = plateau_q;
        if (flush) begin
            plateau_d = '0;
        end else if (metric_valid_q && (state_q == ST_SEARCH)) begin
            plateau_d = qual_q ? plateau_inc : 8'd0;
        end
    end

    // All state registers, asynchronously cleared
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q        <= ST_IDLE;
            for (int k = 0; k < LAG; k++) dl_q[k] <= '0;
            warm_cnt_q     <= '0;
            prod_re_q      <= '0;
            prod_im_q      <= '0;
            pwr_q          <= '0;
            v1_q           <= 1'b0;
            warm1_q        <= 1'b0;
            for (int k = 0; k < WIN; k++) begin
                hre_q[k] <= '0;
                him_q[k] <= '0;
                hpw_q[k] <= '0;
            end
            sum_re_q       <= '0;
            sum_im_q       <= '0;
            sum_pwr_q      <= '0;
            v2_q           <= 1'b0;
            warm2_q        <= 1'b0;
            qual_q         <= 1'b0;
            metric_valid_q <= 1'b0;
            plateau_q      <= '0;
        end else begin
            state_q        <= state_d;
            dl_q           <= dl_d;
            warm_cnt_q     <= warm_cnt_d;
            prod_re_q      <= prod_re_d;
            prod_im_q      <= prod_im_d;
            pwr_q          <= pwr_d;
            v1_q           <= v1_d;
            warm1_q        <= warm1_d;
            hre_q          <= hre_d;
            him_q          <= him_d;
            hpw_q          <= hpw_d;
            sum_re_q       <= sum_re_d;
            sum_im_q       <= sum_im_d;
            sum_pwr_q      <= sum_pwr_d;
            v2_q           <= v2_d;
            warm2_q        <= warm2_d;
            qual_q         <= qual_d;
            metric_valid_q <= metric_valid_d;
            plateau_q      <= plateau_d;
        end
    end

`ifdef STF_SYNC_CORR_LATCH_EN
    // S3 copies of the sums keep the capture aligned with the metric that hits
    logic signed [39:0] cs3_re_q, cs3_re_d, cs3_im_q, cs3_im_d;
    logic signed [39:0] lat_re_q, lat_re_d, lat_im_q, lat_im_d;

    // Capture sums at the detecting metric; hold across clear/disable
    always_comb begin
        cs3_re_d = cs3_re_q;
        cs3_im_d = cs3_im_q;
        lat_re_d = lat_re_q;
        lat_im_d = lat_im_q;
        if (flush) begin
            cs3_re_d = '0;
            cs3_im_d = '0;
        end else if (v2_q) begin
            cs3_re_d = sum_re_q;
            cs3_im_d = sum_im_q;
        end
        if (hit) begin
            lat_re_d = cs3_re_q;
            lat_im_d = cs3_im_q;
        end
    end

    // Capture registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cs3_re_q <= '0;
            cs3_im_q <= '0;
            lat_re_q <= '0;
            lat_im_q <= '0;
        end else begin
            cs3_re_q <= cs3_re_d;
            cs3_im_q <= cs3_im_d;
            lat_re_q <= lat_re_d;
            lat_im_q <= lat_im_d;
        end
    end

    assign corr_re_latched = lat_re_q;
    assign corr_im_latched = lat_im_q;
`else
    assign corr_re_latched = '0;
    assign corr_im_latched = '0;
`endif

    assign metric_valid            = metric_valid_q;
    assign plateau_cnt             = plateau_q;
    assign short_preamble_detected = (state_q == ST_DETECTED);

endmodule

// File: tb/tb_stf_sync_detect.sv
// ---------------------------------------------------------------------------
// tb_stf_sync_detect
// Scoreboard bench: each driven strobe is run through a direct window-sum
// reference of the detector and its expected plateau/detect state is queued.
// Each metric_valid pops one entry. That entry's latency is checked at once.
// Its plateau/detect values are checked on the following cycle.
// ---------------------------------------------------------------------------
module tb_stf_sync_detect;

    logic        clk = 1'b0;
    logic        rstn;
    logic        enable;
    logic        clear;
    logic [31:0] sample_in;
    logic        sample_in_strobe;
    logic        metric_valid;
    logic [7:0]  plateau_cnt;
    logic        short_preamble_detected;
    logic [39:0] corr_re_latched;
    logic [39:0] corr_im_latched;

    stf_sync_detect dut (
        .clk                     (clk),
        .rstn                    (rstn),
        .enable                  (enable),
        .clear                   (clear),
        .sample_in               (sample_in),
        .sample_in_strobe        (sample_in_strobe),
        .metric_valid            (metric_valid),
        .plateau_cnt             (plateau_cnt),
        .short_preamble_detected (short_preamble_detected),
        .corr_re_latched         (corr_re_latched),
        .corr_im_latched         (corr_im_latched)
    );

    always #5 clk = ~clk;

    // One period of the legacy STF, peak magnitude 0x042a
    int stf_i [16] = '{ 343, -984,  -97, 1066, 686, 1066,  -97, -984,
                        343,   15, -589,  -97,   0,  -97, -589,   15};
    int stf_q [16] = '{ 343,   15, -589,  -97,   0,  -97, -589,   15,
                        343, -984,  -97, 1066, 686, 1066,  -97, -984};
    int stf_ph = 0;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    typedef struct {
        int stamp;
        int plateau;
        bit det;
        int idx;
    } exp_t;

    exp_t sb_q[$];
    exp_t pend;
    bit   pend_valid = 1'b0;

    // Reference state
    int     hist_i [2048];
    int     hist_q [2048];
    int     m_k;
    int     m_plat;
    bit     m_det;
    longint m_lat_re;
    longint m_lat_im;

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic longint samp_i(input int k);
        if (k < 1) return 0;
        return longint'(hist_i[k-1]);
    endfunction

    function automatic longint samp_q(input int k);
        if (k < 1) return 0;
        return longint'(hist_q[k-1]);
    endfunction

    function automatic longint labs(input longint v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic model_restart();
        m_k    = 0;
        m_plat = 0;
        m_det  = 1'b0;
    endtask

    // Direct evaluation of the 16-sample window ending at the newest sample
    task automatic model_push(input int si, input int sq);
        longint re, im, pw, ic, qc, id, qd;
        bit     qual;
        exp_t   e;
        m_k++;
        hist_i[m_k-1] = si;
        hist_q[m_k-1] = sq;
        re = 0; im = 0; pw = 0;
        for (int j = m_k - 15; j <= m_k; j++) begin
            if (j >= 1) begin
                ic = samp_i(j);      qc = samp_q(j);
                id = samp_i(j - 16); qd = samp_q(j - 16);
                re += (ic * id + qc * qd) >>> 4;
                im += (qc * id - ic * qd) >>> 4;
                pw += (ic * ic + qc * qc) >>> 4;
            end
        end
        qual = (m_k >= 33) && (pw >= 64) && (8 * (labs(re) + labs(im)) > 6 * pw);
        if (!m_det) begin
            if (qual) m_plat = (m_plat == 255) ? 255 : m_plat + 1;
            else      m_plat = 0;
            if (m_plat == 100) begin
                m_det    = 1'b1;
                m_lat_re = re;
                m_lat_im = im;
            end
        end
        e.stamp = cyc;
        e.plateau = m_plat;
        e.det = m_det;
        e.idx = m_k;
        sb_q.push_back(e);
    endtask

    task automatic send(input int si, input int sq);
        sample_in        = {si[15:0], sq[15:0]};
        sample_in_strobe = 1'b1;
        model_push(si, sq);
        @(posedge clk); #1;
    endtask

    task automatic send_stf(input int n);
        for (int s = 0; s < n; s++) begin
            send(stf_i[stf_ph], stf_q[stf_ph]);
            stf_ph = (stf_ph + 1) % 16;
        end
    endtask

    task automatic send_zero(input int n);
        for (int s = 0; s < n; s++) send(0, 0);
    endtask

    task automatic idle_cycles(input int n);
        sample_in_strobe = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_enable();
        enable = 1'b1;
        @(posedge clk); #1;
        model_restart();
    endtask

    task automatic check_latch(input string tag);
        longint exp_re, exp_im;
`ifdef STF_SYNC_CORR_LATCH_EN
        exp_re = m_lat_re;
        exp_im = m_lat_im;
`else
        exp_re = 0;
        exp_im = 0;
`endif
        check_val({tag, "_lat_re"}, $signed(corr_re_latched), exp_re);
        check_val({tag, "_lat_im"}, $signed(corr_im_latched), exp_im);
    endtask

    // Cycle counter
    initial begin
        forever begin
            @(posedge clk);
            cyc <= cyc + 1;
        end
    end

    // Output monitor: consumes one scoreboard entry per metric
    initial begin
        forever begin
            @(negedge clk);
            if (rstn) begin
                if (pend_valid) begin
                    check_val("plateau_cnt", plateau_cnt, pend.plateau);
                    check_val("detected", short_preamble_detected, pend.det);
                    $display("metric strobe=%0d plateau=%0d det=%0b exp_plateau=%0d exp_det=%0b",
                             pend.idx, plateau_cnt, short_preamble_detected, pend.plateau, pend.det);
                    pend_valid = 1'b0;
                end
                if (metric_valid) begin
                    if (sb_q.size() == 0) begin
                        check_val("sb_underflow", metric_valid, 0);
                    end else begin
                        pend = sb_q.pop_front();
                        check_val("metric_latency", cyc - pend.stamp, 3);
                        pend_valid = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        rstn = 1'b0; enable = 1'b0; clear = 1'b0;
        sample_in = '0; sample_in_strobe = 1'b0;
        m_lat_re = 0; m_lat_im = 0;
        model_restart();
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_metric_valid", metric_valid, 0);
        check_val("rst_plateau", plateau_cnt, 0);
        check_val("rst_detected", short_preamble_detected, 0);
        check_val("rst_lat_re", $signed(corr_re_latched), 0);
        check_val("rst_lat_im", $signed(corr_im_latched), 0);
        rstn = 1'b1;
        @(posedge clk); #1;

        // Periodic STF: qualify from strobe 33, detect after strobe 132
        do_enable();
        send_stf(160);
        idle_cycles(8);
        check_val("stf_detected", short_preamble_detected, 1);
        check_val("stf_plateau_frozen", plateau_cnt, 100);
        check_latch("stf");
`ifdef STF_SYNC_CORR_LATCH_EN
        check_val("stf_lat_im_zero", $signed(corr_im_latched), 0);
        check_val("stf_lat_re_pos", ($signed(corr_re_latched) > 0) ? 1 : 0, 1);
`endif

        // Clear out of DETECTED, then re-detect on continued STF
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        check_val("clr_detected", short_preamble_detected, 0);
        check_val("clr_plateau", plateau_cnt, 0);
        model_restart();
        send_stf(140);
        idle_cycles(8);
        check_val("redetect", short_preamble_detected, 1);
        check_latch("redetect");

        // Disable drops everything back to IDLE
        enable = 1'b0;
        @(posedge clk); #1;
        check_val("dis_detected", short_preamble_detected, 0);
        check_val("dis_plateau", plateau_cnt, 0);
        model_restart();

        // All-zero input never qualifies
        do_enable();
        send_zero(500);
        idle_cycles(8);
        check_val("zero_detected", short_preamble_detected, 0);
        check_val("zero_plateau", plateau_cnt, 0);

        // STF interrupted by a 16-sample gap, then resumed
        enable = 1'b0;
        @(posedge clk); #1;
        do_enable();
        send_stf(90);
        send_zero(16);
        send_stf(200);
        check_val("gap_detected", short_preamble_detected, 1);

        // Asynchronous reset mid-stream clears outputs immediately
        #2;
        rstn = 1'b0;
        sb_q.delete();
        pend_valid = 1'b0;
        #1;
        check_val("arst_metric_valid", metric_valid, 0);
        check_val("arst_plateau", plateau_cnt, 0);
        check_val("arst_detected", short_preamble_detected, 0);
        check_val("arst_lat_re", $signed(corr_re_latched), 0);
        check_val("arst_lat_im", $signed(corr_im_latched), 0);
        sample_in_strobe = 1'b0;
        enable = 1'b0;
        m_lat_re = 0; m_lat_im = 0;
        model_restart();
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
        do_enable();
        send_stf(160);
        idle_cycles(8);
        check_val("post_rst_detected", short_preamble_detected, 1);
        check_latch("post_rst");

        check_val("sb_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
